// File: rtl/data_access_ctrl_pkg.sv
// Shared op codes, pointer modes, state encoding and memory region bounds.
package data_access_ctrl_pkg;

  localparam logic [2:0] OP_LD   = 3'b000;
  localparam logic [2:0] OP_ST   = 3'b001;
  localparam logic [2:0] OP_PUSH = 3'b010;
  localparam logic [2:0] OP_POP  = 3'b011;
  localparam logic [2:0] OP_IN   = 3'b100;
  localparam logic [2:0] OP_OUT  = 3'b101;

  localparam logic [1:0] PM_DIRECT   = 2'b00;
  localparam logic [1:0] PM_POST_INC = 2'b01;
  localparam logic [1:0] PM_PRE_DEC  = 2'b10;
  localparam logic [1:0] PM_DISP     = 2'b11;

  localparam logic [15:0] SP_RESET_DEF = 16'h085F;
  localparam logic [15:0] REG_TOP      = 16'h001F;
  localparam logic [15:0] IO_TOP       = 16'h005F;
  localparam logic [15:0] SRAM_TOP     = 16'h085F;

  localparam int unsigned RD_LAT_DEF = 3;
  localparam int unsigned WR_LAT_DEF = 2;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Request fields captured when start is accepted.
  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  mode;
    logic [15:0] addr;
    logic [15:0] ptr;
    logic [5:0]  disp;
    logic [7:0]  wdata;
  } req_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_OUT;
  endfunction

  function automatic logic op_is_write(input logic [2:0] op);
    return (op == OP_ST) || (op == OP_PUSH) || (op == OP_OUT);
  endfunction

  function automatic logic op_is_io(input logic [2:0] op);
    return (op == OP_IN) || (op == OP_OUT);
  endfunction

endpackage

// File: rtl/data_access_ctrl_addr_gen.sv
// Effective address, pointer write-back and next-SP computation for one request.
import data_access_ctrl_pkg::*;

module data_addr_gen (
  input  logic [2:0]  op,
  input  logic [1:0]  ptr_mode,
  input  logic [15:0] addr_in,
  input  logic [15:0] ptr_in,
  input  logic [5:0]  disp,
  input  logic [15:0] sp,
  output logic [15:0] eff_addr_c,
  output logic [15:0] ptr_out_c,
  output logic        ptr_we_c,
  output logic [15:0] sp_next_c,
  output logic        sp_we_c
);

  // Address arithmetic is 16-bit modular; wrap is silent.
  always_comb begin
    eff_addr_c = addr_in;
    ptr_out_c  = ptr_in;
    ptr_we_c   = 1'b0;
    sp_next_c  = sp;
    sp_we_c    = 1'b0;
    case (op)
      OP_LD, OP_ST: begin
        case (ptr_mode)
          PM_DIRECT: eff_addr_c = addr_in;
          PM_POST_INC: begin
            eff_addr_c = ptr_in;
            ptr_out_c  = ptr_in + 16'd1;
            ptr_we_c   = 1'b1;
          end
          PM_PRE_DEC: begin
            eff_addr_c = ptr_in - 16'd1;
            ptr_out_c  = ptr_in - 16'd1;
            ptr_we_c   = 1'b1;
          end
          default: eff_addr_c = ptr_in + {10'b0, disp};
        endcase
      end
      OP_PUSH: begin
        eff_addr_c = sp;
        sp_next_c  = sp - 16'd1;
        sp_we_c    = 1'b1;
      end
      OP_POP: begin
        eff_addr_c = sp + 16'd1;
        sp_next_c  = sp + 16'd1;
        sp_we_c    = 1'b1;
      end
      OP_IN, OP_OUT: eff_addr_c = {10'b0, addr_in[5:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_access_ctrl.sv
// Sequences one data request into timed memory_map bus activity; owns the SP.
import data_access_ctrl_pkg::*;

module data_access_ctrl #(
  parameter int unsigned RD_LAT   = RD_LAT_DEF,
  parameter int unsigned WR_LAT   = WR_LAT_DEF,
  parameter logic [15:0] SP_RESET = SP_RESET_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [1:0]  ptr_mode,
  input  logic [15:0] addr_in,
  input  logic [15:0] ptr_in,
  input  logic [5:0]  disp,
  input  logic [7:0]  wdata,
  input  logic [7:0]  mm_q,
  input  logic        sp_load,
  input  logic [15:0] sp_load_val,
  output logic [15:0] mm_addr,
  output logic        mm_we,
  output logic [7:0]  mm_data,
  output logic        mm_io_only,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic [15:0] ptr_out,
  output logic        ptr_we,
  output logic [15:0] sp
);

  state_t             state;
  req_t               req;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        sp_pend;
  logic               sp_pend_we;
  logic               ptr_pend_we;

  logic [15:0]        eff_addr_c;
  logic [15:0]        ptr_out_c;
  logic               ptr_we_c;
  logic [15:0]        sp_next_c;
  logic               sp_we_c;

  data_addr_gen u_addr_gen (
    .op         (req.op),
    .ptr_mode   (req.mode),
    .addr_in    (req.addr),
    .ptr_in     (req.ptr),
    .disp       (req.disp),
    .sp         (sp),
    .eff_addr_c (eff_addr_c),
    .ptr_out_c  (ptr_out_c),
    .ptr_we_c   (ptr_we_c),
    .sp_next_c  (sp_next_c),
    .sp_we_c    (sp_we_c)
  );

  // Request FSM, bus drive, read capture and SP/pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      req         <= '0;
      cnt         <= '0;
      sp_pend     <= '0;
      sp_pend_we  <= 1'b0;
      ptr_pend_we <= 1'b0;
      mm_addr     <= '0;
      mm_we       <= 1'b0;
      mm_data     <= '0;
      mm_io_only  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rdata       <= '0;
      ptr_out     <= '0;
      ptr_we      <= 1'b0;
      sp          <= SP_RESET;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      ptr_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            req   <= '{op: op, mode: ptr_mode, addr: addr_in, ptr: ptr_in,
                       disp: disp, wdata: wdata};
            busy  <= 1'b1;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (!op_legal(req.op)) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            mm_addr     <= eff_addr_c;
            mm_data     <= req.wdata;
            mm_we       <= op_is_write(req.op);
            mm_io_only  <= op_is_io(req.op);
            cnt         <= op_is_write(req.op) ? CNT_W'(WR_LAT - 1) : CNT_W'(RD_LAT - 1);
            sp_pend     <= sp_next_c;
            sp_pend_we  <= sp_we_c;
            ptr_pend_we <= ptr_we_c;
            if (ptr_we_c) ptr_out <= ptr_out_c;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          mm_we <= 1'b0;
          if (cnt == '0) begin
            if (!op_is_write(req.op)) rdata <= mm_q;
            if (sp_pend_we) sp <= sp_pend;
            ptr_we <= ptr_pend_we;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
      // An explicit SP load overrides any stack-op update on the same edge.
      if (sp_load) sp <= sp_load_val;
    end
  end

endmodule

// File: tb/tb_data_access_ctrl.sv
// Table-driven scoreboard bench for data_access_ctrl with a lagged memory model.
module tb_data_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [1:0]  ptr_mode;
  logic [15:0] addr_in;
  logic [15:0] ptr_in;
  logic [5:0]  disp;
  logic [7:0]  wdata;
  logic [7:0]  mm_q;
  logic        sp_load;
  logic [15:0] sp_load_val;
  logic [15:0] mm_addr;
  logic        mm_we;
  logic [7:0]  mm_data;
  logic        mm_io_only;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  rdata;
  logic [15:0] ptr_out;
  logic        ptr_we;
  logic [15:0] sp;

  int checks = 0;
  int errors = 0;

  data_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .ptr_mode(ptr_mode),
    .addr_in(addr_in), .ptr_in(ptr_in), .disp(disp), .wdata(wdata), .mm_q(mm_q),
    .sp_load(sp_load), .sp_load_val(sp_load_val), .mm_addr(mm_addr), .mm_we(mm_we),
    .mm_data(mm_data), .mm_io_only(mm_io_only), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .ptr_out(ptr_out), .ptr_we(ptr_we), .sp(sp)
  );

  always #5 clk = ~clk;

  // memory_map stand-in: Q follows the address with a two-cycle lag.
  logic [7:0] mem [logic [15:0]];
  logic [7:0] q1;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return (a == 16'h0065) ? 8'hA5 : 8'h00;
  endfunction

  always @(posedge clk) begin
    q1   <= mem_rd(mm_addr);
    mm_q <= q1;
    if (mm_we) mem[mm_addr] = mm_data;
  end

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  mode;
    logic [15:0] addr;
    logic [15:0] ptr;
    logic [5:0]  disp;
    logic [7:0]  wd;
    int          hold;
    int          ld_cyc;
    logic [15:0] ld_val;
    int          lat;
    int          we_n;
    logic [15:0] e_addr;
    logic        e_io;
    logic        e_err;
    logic        e_pwe;
    logic [15:0] e_pout;
    logic        chk_rd;
    logic [7:0]  e_rd;
    logic [15:0] e_sp;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];
  vec_t sb [$];

  function automatic vec_t mk(input logic [2:0] o, input logic [1:0] m,
                              input logic [15:0] a, input logic [15:0] p,
                              input logic [5:0] d, input logic [7:0] w,
                              input int h, input int lc, input logic [15:0] lv,
                              input int lat, input int wn, input logic [15:0] ea,
                              input logic eio, input logic eerr, input logic epwe,
                              input logic [15:0] epo, input logic crd,
                              input logic [7:0] erd, input logic [15:0] esp);
    vec_t v;
    v.op = o; v.mode = m; v.addr = a; v.ptr = p; v.disp = d; v.wd = w;
    v.hold = h; v.ld_cyc = lc; v.ld_val = lv; v.lat = lat; v.we_n = wn;
    v.e_addr = ea; v.e_io = eio; v.e_err = eerr; v.e_pwe = epwe; v.e_pout = epo;
    v.chk_rd = crd; v.e_rd = erd; v.e_sp = esp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int we_cnt;
    logic [15:0] a_seen;
    logic io_seen;
    logic got;
    vec_t e;
    sb.push_back(v);
    @(negedge clk);
    op = v.op; ptr_mode = v.mode; addr_in = v.addr; ptr_in = v.ptr;
    disp = v.disp; wdata = v.wd; start = 1'b1;
    sp_load = (v.ld_cyc == 0); sp_load_val = v.ld_val;
    cyc = 0; we_cnt = 0; a_seen = '0; io_seen = 1'b0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start   = (cyc <= v.hold);
      sp_load = (cyc == v.ld_cyc);
      if (cyc == 2) begin a_seen = mm_addr; io_seen = mm_io_only; end
      if (mm_we) we_cnt++;
      if (done) got = 1'b1;
    end
    e = sb.pop_front();
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(cyc), 32'(e.lat));
    chk("we_cycles", 32'(we_cnt), 32'(e.we_n));
    if (!e.e_err) begin
      chk("mm_addr", 32'(a_seen), 32'(e.e_addr));
      chk("io_only", 32'(io_seen), 32'(e.e_io));
    end
    chk("err", 32'(err), 32'(e.e_err));
    chk("ptr_we", 32'(ptr_we), 32'(e.e_pwe));
    if (e.e_pwe) chk("ptr_out", 32'(ptr_out), 32'(e.e_pout));
    if (e.chk_rd) chk("rdata", 32'(rdata), 32'(e.e_rd));
    chk("sp", 32'(sp), 32'(e.e_sp));
    chk("busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0; sp_load = 1'b0;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; ptr_mode = '0; addr_in = '0; ptr_in = '0;
    disp = '0; wdata = '0; sp_load = 1'b0; sp_load_val = '0;

    //                op      md     addr      ptr       disp   wd     h  lc  lv        lat we  e_addr    io   er   pwe  pout      crd  rd     sp
    tbl[0]  = mk(3'b010, 2'b10, 16'h0000, 16'h0000, 6'h00, 8'h11, 0, -1, 16'h0000, 4, 1, 16'h085F, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h085E);
    tbl[1]  = mk(3'b011, 2'b00, 16'h0000, 16'h0000, 6'h00, 8'h00, 0, -1, 16'h0000, 5, 0, 16'h085F, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h11, 16'h085F);
    tbl[2]  = mk(3'b000, 2'b00, 16'h0065, 16'h0000, 6'h00, 8'h00, 0, -1, 16'h0000, 5, 0, 16'h0065, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'hA5, 16'h085F);
    tbl[3]  = mk(3'b001, 2'b01, 16'h0000, 16'h0100, 6'h00, 8'h3C, 0, -1, 16'h0000, 4, 1, 16'h0100, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0, 8'h00, 16'h085F);
    tbl[4]  = mk(3'b000, 2'b10, 16'h0000, 16'h0000, 6'h00, 8'h00, 0, -1, 16'h0000, 5, 0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 8'h00, 16'h085F);
    tbl[5]  = mk(3'b000, 2'b11, 16'h0000, 16'h0200, 6'h3F, 8'h00, 0, -1, 16'h0000, 5, 0, 16'h023F, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h085F);
    tbl[6]  = mk(3'b101, 2'b01, 16'hAB3D, 16'h1234, 6'h00, 8'h5A, 0, -1, 16'h0000, 4, 1, 16'h003D, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h085F);
    tbl[7]  = mk(3'b100, 2'b10, 16'hFF3D, 16'h1234, 6'h00, 8'h00, 0, -1, 16'h0000, 5, 0, 16'h003D, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h5A, 16'h085F);
    tbl[8]  = mk(3'b001, 2'b00, 16'hFFFF, 16'h0000, 6'h00, 8'h77, 0, -1, 16'h0000, 4, 1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h085F);
    tbl[9]  = mk(3'b000, 2'b01, 16'h0000, 16'hFFFF, 6'h00, 8'h00, 0, -1, 16'h0000, 5, 0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 8'h77, 16'h085F);
    tbl[10] = mk(3'b110, 2'b00, 16'h0042, 16'h0000, 6'h00, 8'h00, 0, -1, 16'h0000, 2, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h085F);
    tbl[11] = mk(3'b111, 2'b01, 16'h0000, 16'h0300, 6'h00, 8'h00, 0, -1, 16'h0000, 2, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h085F);
    tbl[12] = mk(3'b001, 2'b11, 16'h0000, 16'h0010, 6'h05, 8'hC3, 3, -1, 16'h0000, 4, 1, 16'h0015, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h085F);
    tbl[13] = mk(3'b000, 2'b11, 16'h0000, 16'h0010, 6'h05, 8'h00, 0,  3, 16'h0000, 5, 0, 16'h0015, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'hC3, 16'h0000);
    tbl[14] = mk(3'b010, 2'b01, 16'h0000, 16'h0000, 6'h00, 8'hEE, 0, -1, 16'h0000, 4, 1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'hFFFF);
    tbl[15] = mk(3'b011, 2'b00, 16'h0000, 16'h0000, 6'h00, 8'h00, 0, -1, 16'h0000, 5, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'hEE, 16'h0000);
    tbl[16] = mk(3'b011, 2'b00, 16'h0000, 16'h0000, 6'h00, 8'h00, 0,  4, 16'h0400, 5, 0, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h0400);

    repeat (3) @(negedge clk);
    chk("rst_mm_addr", 32'(mm_addr), 32'h0000);
    chk("rst_mm_we", 32'(mm_we), 32'd0);
    chk("rst_mm_data", 32'(mm_data), 32'h00);
    chk("rst_io_only", 32'(mm_io_only), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ptr_we", 32'(ptr_we), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_ptr_out", 32'(ptr_out), 32'h0000);
    chk("rst_sp", 32'(sp), 32'h085F);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(tbl[i]);

    // Reset in the middle of a store's write cycle.
    sp_load = 1'b1; sp_load_val = 16'h0700;
    @(negedge clk);
    sp_load = 1'b0;
    op = 3'b001; ptr_mode = 2'b00; addr_in = 16'h0123; wdata = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("we_before_rst", 32'(mm_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 32'(mm_we), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_sp", 32'(sp), 32'h085F);
    @(negedge clk);
    rst_n = 1'b1;

    // Aborted write must not have landed.
    run_vec(mk(3'b000, 2'b00, 16'h0123, 16'h0000, 6'h00, 8'h00, 0, -1, 16'h0000,
               5, 0, 16'h0123, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h085F));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
